pixel_writer: RTL

Avalon-MM write master that sits directly upstream of `vga_unit` in the frame-buffer path. It accepts pixel writes (x, y, colour) from the rasteriser over a valid/ready handshake and buffers them in a small FIFO. It converts each pixel into a 32-bit word write at `frame_buffer_ptr + 4*(y*H_RES + x)` in SDRAM, and also provides a bulk screen-clear command. `vga_unit` then scans the same memory out to the display.

---
 rtl/pixel_writer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_writer: FIFO-buffered pixel/clear Avalon-MM write master into SDRAM. Rev 1.0
// ----------------------------------------------------------------------------
module pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] frame_buffer_ptr,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [23:0] pix_color,
  input  logic        clear_start,
  input  logic [23:0] clear_color,
  output logic        busy,
  output logic        clear_done,
  output logic        pix_dropped,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
);

  localparam int              c_aw        = $clog2(FIFO_DEPTH);
  localparam int              c_words_m1  = H_RES * V_RES - 1;
  localparam logic [c_aw:0]   c_depth     = FIFO_DEPTH[c_aw:0];
  localparam logic [18:0]     c_last_word = c_words_m1[18:0];
  localparam logic [10:0]     c_h_lim     = H_RES[10:0];
  localparam logic [9:0]      c_v_lim     = V_RES[9:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t          r_state;
  logic [42:0]     r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_clear_pending;
  logic [23:0]     r_clear_color;
  logic [18:0]     r_clear_idx;
  logic            r_master_write;
  logic [25:0]     r_master_address;
  logic [31:0]     r_master_writedata;
  logic            r_clear_done;
  logic            r_pix_dropped;

  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_in_range;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [42:0]     w_head;
  logic [9:0]      w_head_x;
  logic [8:0]      w_head_y;
  logic [23:0]     w_head_color;
  logic [25:0]     w_row;
  logic [25:0]     w_pix_addr;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == c_depth);
  assign w_in_range   = ({1'b0, pix_x} < c_h_lim) && ({1'b0, pix_y} < c_v_lim);
  assign pix_ready    = !reset && !w_fifo_full && !r_clear_pending && (r_state != S_CLEAR);
  assign w_accept     = pix_valid && pix_ready;
  assign w_push       = w_accept && w_in_range;
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_WRITE) && !master_waitrequest));

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_x     = w_head[42:33];
  assign w_head_y     = w_head[32:24];
  assign w_head_color = w_head[23:0];

  generate
    if (H_RES == 640) begin : g_row_shift
      assign w_row = ({17'd0, w_head_y} << 9) + ({17'd0, w_head_y} << 7);
    end else begin : g_row_mul
      assign w_row = 26'(w_head_y) * 26'(H_RES);
    end
  endgenerate

  assign w_pix_addr = frame_buffer_ptr + ((w_row + {16'd0, w_head_x}) << 2);

  // Storage needs no reset: the count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {pix_x, pix_y, pix_color};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_clear_pending    <= 1'b0;
      r_clear_color      <= '0;
      r_clear_idx        <= '0;
      r_master_write     <= 1'b0;
      r_master_address   <= '0;
      r_master_writedata <= '0;
      r_clear_done       <= 1'b0;
      r_pix_dropped      <= 1'b0;
    end else begin
      r_pix_dropped <= w_accept && !w_in_range;
      r_clear_done  <= 1'b0;
      if (clear_start && !r_clear_pending && (r_state != S_CLEAR)) begin
        r_clear_pending <= 1'b1;
        r_clear_color   <= clear_color;
      end
      case (r_state)
        S_IDLE: begin
          // Queued pixels take priority so they land before any pending clear.
          if (w_pop) begin
            r_master_address   <= w_pix_addr;
            r_master_writedata <= {8'h00, w_head_color};
            r_master_write     <= 1'b1;
            r_state            <= S_WRITE;
          end else if (r_clear_pending) begin
            r_master_address   <= frame_buffer_ptr;
            r_master_writedata <= {8'h00, r_clear_color};
            r_master_write     <= 1'b1;
            r_clear_idx        <= '0;
            r_state            <= S_CLEAR;
          end
        end
        S_WRITE: begin
          if (!master_waitrequest) begin
            if (w_pop) begin
              r_master_address   <= w_pix_addr;
              r_master_writedata <= {8'h00, w_head_color};
            end else begin
              r_master_write <= 1'b0;
              r_state        <= S_IDLE;
            end
          end
        end
        S_CLEAR: begin
          if (!master_waitrequest) begin
            if (r_clear_idx == c_last_word) begin
              r_master_write  <= 1'b0;
              r_clear_done    <= 1'b1;
              r_clear_pending <= 1'b0;
              r_state         <= S_IDLE;
            end else begin
              r_clear_idx      <= r_clear_idx + 1'b1;
              r_master_address <= r_master_address + 26'd4;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign master_write     = r_master_write;
  assign master_address   = r_master_address;
  assign master_writedata = r_master_writedata;
  assign clear_done       = r_clear_done;
  assign pix_dropped      = r_pix_dropped;
  assign busy             = (r_state != S_IDLE) || !w_fifo_empty || r_clear_pending;

endmodule
`default_nettype wire
